// File: rtl/core_pkg.sv
// Shared types and constants for the RV32E load/store path.
`timescale 1ns/1ps
package core_pkg;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RW     = 4;
    localparam int unsigned NBYTES = XLEN / 8;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [NBYTES-1:0] wstrb;
    } mem_req_t;
endpackage

// File: rtl/lsu_ctrl_if.sv
// Memory request/response bus between the LSU (master) and memory (slave).
`timescale 1ns/1ps
interface lsu_ctrl_if;
    import core_pkg::*;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [XLEN-1:0]   mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [NBYTES-1:0] mem_req_wstrb;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Store lane/strobe generation, load byte/half extraction with extension,
// and misalignment / illegal-encoding detection.
`timescale 1ns/1ps
module lsu_align
    import core_pkg::*;
(
    input  funct3_t           funct3,
    input  logic              is_load,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata_c,
    output logic [NBYTES-1:0] wstrb_c,
    output logic [XLEN-1:0]   ld_data_c,
    output logic              fault_c
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        wdata_c   = st_data;
        wstrb_c   = '1;
        ld_data_c = rdata;
        fault_c   = 1'b0;
        case (funct3)
            F3_B: begin
                wdata_c   = {4{st_data[7:0]}};
                wstrb_c   = 4'b0001 << offset;
                ld_data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                wdata_c   = {2{st_data[15:0]}};
                wstrb_c   = 4'b0011 << offset;
                ld_data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault_c   = offset[0];
            end
            F3_W: begin
                fault_c   = |offset;
            end
            // Unsigned forms exist only for loads.
            F3_BU: begin
                ld_data_c = {{(XLEN-8){1'b0}}, byte_sel};
                fault_c   = !is_load;
            end
            F3_HU: begin
                ld_data_c = {{(XLEN-16){1'b0}}, half_sel};
                fault_c   = !is_load || offset[0];
            end
            default: begin
                fault_c   = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// RV32E load/store unit: effective address, single-outstanding memory
// handshake, and aligned load write-back toward core control.
`timescale 1ns/1ps
module lsu_ctrl
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            lsu_en,
    input  logic            is_load,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] st_data,
    input  logic [RW-1:0]   rd,
    lsu_ctrl_if.master      mem,
    output logic            lsu_busy,
    output logic            ls_load_ready,
    output logic [RW-1:0]   ld_rd,
    output logic [XLEN-1:0] ld_data,
    output logic            ls_fault
);
    lsu_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              req_valid_q, req_valid_d;
    logic              op_load_q;
    funct3_t           op_f3_q;
    logic [1:0]        op_off_q;
    logic [RW-1:0]     op_rd_q;
    logic              fault_d, load_ready_d, accept;
    logic [XLEN-1:0]   addr;
    funct3_t           al_f3;
    logic              al_load;
    logic [1:0]        al_off;
    logic [XLEN-1:0]   al_wdata, al_ld_data;
    logic [NBYTES-1:0] al_wstrb;
    logic              al_fault;

    assign addr   = base + imm;
    assign accept = (state_q == IDLE) && lsu_en;

    // Align unit sees the live op while idle, the latched op once in flight.
    assign al_f3   = (state_q == IDLE) ? funct3_t'(funct3) : op_f3_q;
    assign al_load = (state_q == IDLE) ? is_load : op_load_q;
    assign al_off  = (state_q == IDLE) ? addr[1:0] : op_off_q;

    lsu_align u_align (
        .funct3    (al_f3),
        .is_load   (al_load),
        .offset    (al_off),
        .st_data   (st_data),
        .rdata     (mem.mem_rsp_rdata),
        .wdata_c   (al_wdata),
        .wstrb_c   (al_wstrb),
        .ld_data_c (al_ld_data),
        .fault_c   (al_fault)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_valid_d  = req_valid_q;
        fault_d      = 1'b0;
        load_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_en) begin
                    if (al_fault) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_d.we    = !is_load;
                        req_d.addr  = {addr[XLEN-1:2], 2'b00};
                        req_d.wdata = is_load ? '0 : al_wdata;
                        req_d.wstrb = is_load ? '0 : al_wstrb;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d = op_load_q ? DONE : IDLE;
                    // x0 loads complete silently so control never bypasses them.
                    load_ready_d = op_load_q && (op_rd_q != '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q         <= '0;
            req_valid_q   <= 1'b0;
            op_load_q     <= 1'b0;
            op_f3_q       <= F3_B;
            op_off_q      <= '0;
            op_rd_q       <= '0;
            lsu_busy      <= 1'b0;
            ls_load_ready <= 1'b0;
            ls_fault      <= 1'b0;
            ld_rd         <= '0;
            ld_data       <= '0;
        end else begin
            req_q         <= req_d;
            req_valid_q   <= req_valid_d;
            lsu_busy      <= (state_d != IDLE);
            ls_load_ready <= load_ready_d;
            ls_fault      <= fault_d;
            if (accept) begin
                op_load_q <= is_load;
                op_f3_q   <= funct3_t'(funct3);
                op_off_q  <= addr[1:0];
                op_rd_q   <= rd;
            end
            if (load_ready_d) begin
                ld_rd   <= op_rd_q;
                ld_data <= al_ld_data;
            end
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_we    = req_q.we;
    assign mem.mem_req_addr  = req_q.addr;
    assign mem.mem_req_wdata = req_q.wdata;
    assign mem.mem_req_wstrb = req_q.wstrb;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.
`timescale 1ns/1ps
module tb_lsu_ctrl;
    import core_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            lsu_en;
    logic            is_load;
    logic [2:0]      funct3;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] st_data;
    logic [RW-1:0]   rd;
    logic            lsu_busy;
    logic            ls_load_ready;
    logic [RW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ls_fault;

    int checks   = 0;
    int failures = 0;

    lsu_ctrl_if mem_bus ();

    lsu_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .lsu_en        (lsu_en),
        .is_load       (is_load),
        .funct3        (funct3),
        .base          (base),
        .imm           (imm),
        .st_data       (st_data),
        .rd            (rd),
        .mem           (mem_bus),
        .lsu_busy      (lsu_busy),
        .ls_load_ready (ls_load_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ls_fault      (ls_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] sd, input logic [3:0] r);
        lsu_en  = 1'b1;
        is_load = ld;
        funct3  = f3;
        base    = b;
        imm     = i;
        st_data = sd;
        rd      = r;
    endtask

    // One full transaction with 'stall' cycles of ready=0 and a one-cycle response.
    task automatic txn(input string tag, input logic ld, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] i, input logic [31:0] sd,
                       input logic [3:0] r, input logic [31:0] rdata, input int stall,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_wstrb, input logic e_pulse,
                       input logic [3:0] e_rd, input logic [31:0] e_data);
        mem_bus.mem_req_ready = 1'b0;
        issue(ld, f3, b, i, sd, r);
        step();
        lsu_en = 1'b0;
        check({tag, " req_valid"}, 32'(mem_bus.mem_req_valid), 32'd1);
        check({tag, " addr"}, mem_bus.mem_req_addr, e_addr);
        check({tag, " we"}, 32'(mem_bus.mem_req_we), 32'(!ld));
        check({tag, " busy"}, 32'(lsu_busy), 32'd1);
        if (!ld) begin
            check({tag, " wdata"}, mem_bus.mem_req_wdata, e_wdata);
            check({tag, " wstrb"}, 32'(mem_bus.mem_req_wstrb), 32'(e_wstrb));
        end
        for (int k = 0; k < stall; k++) begin
            issue(1'b0, 3'b010, 32'h0000_0F00, 32'h0, 32'hFFFF_FFFF, 4'd1);
            step();
            lsu_en = 1'b0;
            check({tag, " stall valid"}, 32'(mem_bus.mem_req_valid), 32'd1);
            check({tag, " stall addr"}, mem_bus.mem_req_addr, e_addr);
            if (!ld) begin
                check({tag, " stall wdata"}, mem_bus.mem_req_wdata, e_wdata);
                check({tag, " stall wstrb"}, 32'(mem_bus.mem_req_wstrb), 32'(e_wstrb));
            end
        end
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        check({tag, " valid drop"}, 32'(mem_bus.mem_req_valid), 32'd0);
        check({tag, " no early pulse"}, 32'(ls_load_ready), 32'd0);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = rdata;
        step();
        mem_bus.mem_rsp_valid = 1'b0;
        check({tag, " load_ready"}, 32'(ls_load_ready), 32'(e_pulse));
        check({tag, " ld_data"}, ld_data, e_data);
        if (e_pulse) check({tag, " ld_rd"}, 32'(ld_rd), 32'(e_rd));
        check({tag, " busy after rsp"}, 32'(lsu_busy), 32'(ld));
        step();
        check({tag, " pulse width"}, 32'(ls_load_ready), 32'd0);
        check({tag, " idle"}, 32'(lsu_busy), 32'd0);
        check({tag, " no reissue"}, 32'(mem_bus.mem_req_valid), 32'd0);
    endtask

    task automatic fault_op(input string tag, input logic ld, input logic [2:0] f3,
                            input logic [31:0] b, input logic [31:0] i);
        issue(ld, f3, b, i, 32'h5555_AAAA, 4'd2);
        step();
        lsu_en = 1'b0;
        check({tag, " fault"}, 32'(ls_fault), 32'd1);
        check({tag, " no req"}, 32'(mem_bus.mem_req_valid), 32'd0);
        step();
        check({tag, " fault width"}, 32'(ls_fault), 32'd0);
        check({tag, " no req later"}, 32'(mem_bus.mem_req_valid), 32'd0);
        check({tag, " busy"}, 32'(lsu_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        lsu_en = 1'b0; is_load = 1'b0; funct3 = 3'b000;
        base = '0; imm = '0; st_data = '0; rd = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_rdata = '0;
        step(); step();
        reset = 1'b0;
        step();
        check("reset busy", 32'(lsu_busy), 32'd0);
        check("reset valid", 32'(mem_bus.mem_req_valid), 32'd0);
        check("reset load_ready", 32'(ls_load_ready), 32'd0);
        check("reset ld_data", ld_data, 32'd0);
        check("reset fault", 32'(ls_fault), 32'd0);

        txn("LW",  1, 3'b010, 32'h100, 32'h4, 0, 4'd5, 32'hDEAD_BEEF, 0,
            32'h104, 0, 4'h0, 1, 4'd5, 32'hDEAD_BEEF);
        txn("LB",  1, 3'b000, 32'h100, 32'h3, 0, 4'd6, 32'h80FF_0000, 0,
            32'h100, 0, 4'h0, 1, 4'd6, 32'hFFFF_FF80);
        txn("LBU", 1, 3'b100, 32'h100, 32'h3, 0, 4'd6, 32'h80FF_0000, 0,
            32'h100, 0, 4'h0, 1, 4'd6, 32'h0000_0080);
        txn("LHU", 1, 3'b101, 32'h100, 32'h2, 0, 4'd6, 32'h80FF_0000, 0,
            32'h100, 0, 4'h0, 1, 4'd6, 32'h0000_80FF);
        txn("LH neg imm", 1, 3'b001, 32'h200, 32'hFFFF_FFFE, 0, 4'd7, 32'h80FF_0000, 0,
            32'h1FC, 0, 4'h0, 1, 4'd7, 32'hFFFF_80FF);
        txn("SB",  0, 3'b000, 32'h200, 32'h1, 32'h1234_5678, 4'd0, 32'h0, 0,
            32'h200, 32'h7878_7878, 4'b0010, 0, 4'd0, 32'hFFFF_80FF);
        txn("SH stall", 0, 3'b001, 32'h300, 32'h2, 32'hCAFE_BABE, 4'd0, 32'h0, 3,
            32'h300, 32'hBABE_BABE, 4'b1100, 0, 4'd0, 32'hFFFF_80FF);
        txn("SW wrap", 0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'hA5A5_0F0F, 4'd0, 32'h0, 0,
            32'h4, 32'hA5A5_0F0F, 4'b1111, 0, 4'd0, 32'hFFFF_80FF);
        txn("LW x0", 1, 3'b010, 32'h400, 32'h0, 0, 4'd0, 32'h1111_1111, 0,
            32'h400, 0, 4'h0, 0, 4'd0, 32'hFFFF_80FF);
        txn("LB stall", 1, 3'b000, 32'h10, 32'h1, 0, 4'd3, 32'h0000_7F00, 2,
            32'h10, 0, 4'h0, 1, 4'd3, 32'h0000_007F);

        fault_op("LW mis",    1, 3'b010, 32'h100, 32'h2);
        fault_op("LH mis",    1, 3'b001, 32'h100, 32'h1);
        fault_op("L f3 011",  1, 3'b011, 32'h100, 32'h0);
        fault_op("S f3 100",  0, 3'b100, 32'h100, 32'h0);
        fault_op("SH mis",    0, 3'b001, 32'h100, 32'h3);

        // Reset while waiting for a load response.
        mem_bus.mem_req_ready = 1'b1;
        issue(1, 3'b010, 32'h500, 32'h0, 0, 4'd9);
        step();
        lsu_en = 1'b0;
        step();
        mem_bus.mem_req_ready = 1'b0;
        check("pre-reset busy", 32'(lsu_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async reset busy", 32'(lsu_busy), 32'd0);
        check("async reset ld_data", ld_data, 32'd0);
        check("async reset ld_rd", 32'(ld_rd), 32'd0);
        step();
        reset = 1'b0;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = 32'hBAD0_BAD0;
        step();
        mem_bus.mem_rsp_valid = 1'b0;
        check("late rsp pulse", 32'(ls_load_ready), 32'd0);
        check("late rsp ld_data", ld_data, 32'd0);
        check("late rsp busy", 32'(lsu_busy), 32'd0);
        step();
        check("late rsp pulse2", 32'(ls_load_ready), 32'd0);

        txn("LW x0 post-reset", 1, 3'b010, 32'h600, 32'h0, 0, 4'd0, 32'h1234_5678, 0,
            32'h600, 0, 4'h0, 0, 4'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit for the RV32E core; sits directly upstream of the core control block.
- Accepts one memory op per `lsu_en` pulse and computes the effective address.
- Runs the memory request/response handshake and aligns/extends load data.
- Returns loads as a one-cycle `ls_load_ready` pulse plus `ld_rd`/`ld_data`, which control uses for register write-back and load bypass.

Parameters:
- XLEN, 32, data and address width
- RW, 4, register index width (16 architectural registers)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- lsu_en  in  1  issue strobe from control; valid only while lsu_busy=0
- is_load  in  1  1=load, 0=store; sampled with lsu_en
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- base  in  XLEN  rs1 value
- imm  in  XLEN  sign-extended offset
- st_data  in  XLEN  rs2 value for stores
- rd  in  RW  load destination
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write enable
- mem_req_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  XLEN  store data replicated into lanes
- mem_req_wstrb  out  4  byte enables
- mem_rsp_valid  in  1  response/write-ack valid, one cycle
- mem_rsp_rdata  in  XLEN  read word
- lsu_busy  out  1  state != IDLE
- ls_load_ready  out  1  one-cycle load-complete pulse
- ld_rd  out  RW  destination of completed load
- ld_data  out  XLEN  aligned, extended load result
- ls_fault  out  1  one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; all outputs are 0; any outstanding transaction is dropped.
  - A `mem_rsp_valid` arriving while in IDLE is ignored.
- Accept: in IDLE, `lsu_en` registers the op.
  - addr = base + imm, modulo 2^32 (wraps, no carry-out).
  - `lsu_en` while busy is ignored.
- Fault check on the accept cycle:
  - H/HU with addr[0]=1, W with addr[1:0]≠0, or funct3 not in {000, 001, 010, 100, 101}, or store with funct3[2]=1.
  - On fault: no memory request; `ls_fault` pulses the next cycle; state returns to IDLE.
- States:
  - IDLE -(accept, no fault)-> REQ
  - REQ: `mem_req_valid`=1, outputs held stable until `mem_req_ready`; -(ready)-> WAIT
  - WAIT -(mem_rsp_valid)-> DONE for loads, IDLE for stores
  - DONE: `ls_load_ready`=1 for exactly one cycle -> IDLE
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], wdata = {4{st_data[7:0]}}
  - H: wstrb = 0011 << addr[1:0], wdata = {2{st_data[15:0]}}
  - W: wstrb = 1111
- Load extract: byte/half selected by addr[1:0]; sign-extended for B/H, zero-extended for BU/HU.
- `ld_rd` and `ld_data` are registered on the response and hold until the next load completes.
- Load with rd=0: full bus transaction occurs, but `ls_load_ready` is suppressed, preventing spurious x0 bypass.
- Minimum load latency: accept at cycle t → `mem_req_valid` at t+1 → response at t+2 → `ls_load_ready` at t+3.
- Each added cycle of ready or response stall adds one cycle of latency.
- Only one transaction is outstanding at a time.

Decomposition:
- Shared package `core_pkg`:
  - funct3 encodings as a typedef enum
  - `lsu_state_t` {IDLE, REQ, WAIT, DONE}
  - XLEN/RW constants
- One combinational sub-module, `lsu_align`: store lane/strobe generation, load extraction/extension, misalignment detection.

Test Plan:
- LW, base=0x100, imm=4, ready=1, rsp at next cycle with rdata=0xDEADBEEF, rd=5 → req addr 0x104, `ls_load_ready` at t+3, ld_rd=5, ld_data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80FF_0000 → ld_data=0xFFFFFF80; LBU same → 0x00000080; LHU addr=0x102 → 0x000080FF.
- SB, st_data=0x12345678, addr=0x201 → wstrb=0010, wdata=0x78787878, we=1; ack → IDLE, no `ls_load_ready`.
- LW at addr=0x102 → `ls_fault` pulse at t+1, `mem_req_valid` never asserted, `lsu_busy` low at t+2.
- `mem_req_ready` held 0 for 3 cycles → addr/wdata/wstrb stable throughout; extra `lsu_en` during busy ignored.
- Reset asserted in WAIT, then late `mem_rsp_valid` after release → no `ls_load_ready`, outputs stay 0; load to rd=0 → no pulse.
